// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, ALU selects and RV32I opcodes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_RFUNCT = 2'b10,
    ALU_IFUNCT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } alu_src_b_e;

  // instruction[6:2] values, shared with the single-cycle control_unit
  localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
  localparam logic [4:0] OPCODE_IARITH = 5'b00100;
  localparam logic [4:0] OPCODE_STORE  = 5'b01000;
  localparam logic [4:0] OPCODE_RTYPE  = 5'b01100;
  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;

  function automatic logic opcode_supported(input logic [4:0] op);
    return (op == OPCODE_LOAD)  || (op == OPCODE_IARITH) || (op == OPCODE_STORE) ||
           (op == OPCODE_RTYPE) || (op == OPCODE_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory request; flags expiry on the TIMEOUT_CYCLES-th cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // count holds the cycles already waited, so LAST marks the threshold cycle itself
  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with unified-memory req/ack handshake and retire counter.
// Optional memory-abort timeout enabled by defining CTRL_MEM_TIMEOUT_EN.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned RET_CNT_W      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [4:0]           opcode_i,
  input  logic                 mem_ack_i,
  output logic                 mem_req_o,
  output logic                 mem_wr_o,
  output logic                 iord_o,
  output logic                 ir_wr_o,
  output logic                 pc_wr_o,
  output logic                 branch_o,
  output logic                 pc_src_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [1:0]           alu_op_o,
  output logic                 mem_to_reg_o,
  output logic                 reg_wr_o,
  output logic                 illegal_o,
  output logic                 instr_done_o,
  output logic [RET_CNT_W-1:0] ret_cnt_o,
  output logic                 mem_timeout_o,
  output logic [2:0]           state_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e                 state_q, state_d;
  logic [4:0]             op_q, op_d;
  logic [RET_CNT_W-1:0]   ret_q, ret_d;
  alu_op_e                alu_op;
  alu_src_b_e             alu_src_b;
  logic                   timeout;

`ifdef CTRL_MEM_TIMEOUT_EN
  logic req_state;
  logic expired;

  assign req_state = (state_q == ST_FETCH) || (state_q == ST_MEM);

  // clearing on timeout makes a FETCH retry start a fresh wait window
  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_wait_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (~req_state | mem_ack_i | timeout),
    .en_i     (req_state & ~mem_ack_i),
    .expired_o(expired)
  );

  assign timeout = req_state & ~mem_ack_i & expired;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_wr_o     = 1'b0;
    iord_o       = 1'b0;
    ir_wr_o      = 1'b0;
    pc_wr_o      = 1'b0;
    branch_o     = 1'b0;
    pc_src_o     = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALU_ADD;
    mem_to_reg_o = 1'b0;
    reg_wr_o     = 1'b0;
    illegal_o    = 1'b0;
    instr_done_o = 1'b0;

    unique case (state_q)
      ST_RESET: state_d = ST_FETCH;

      ST_FETCH: begin
        if (timeout) begin
          state_d = ST_FETCH;
        end else begin
          mem_req_o = 1'b1;
          if (mem_ack_i) begin
            ir_wr_o   = 1'b1;
            pc_wr_o   = 1'b1;
            alu_src_b = SRCB_FOUR;
            state_d   = ST_DECODE;
          end
        end
      end

      ST_DECODE: begin
        alu_src_b = SRCB_IMM;
        if (opcode_supported(opcode_i)) begin
          state_d = ST_EXEC;
        end else begin
          illegal_o = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_EXEC: begin
        alu_src_a_o = 1'b1;
        state_d     = ST_FETCH;
        unique case (op_q)
          OPCODE_RTYPE: begin
            alu_op  = ALU_RFUNCT;
            state_d = ST_WB;
          end
          OPCODE_IARITH: begin
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_IFUNCT;
            state_d   = ST_WB;
          end
          OPCODE_LOAD, OPCODE_STORE: begin
            alu_src_b = SRCB_IMM;
            state_d   = ST_MEM;
          end
          OPCODE_BRANCH: begin
            alu_op       = ALU_SUB;
            branch_o     = 1'b1;
            pc_src_o     = 1'b1;
            instr_done_o = 1'b1;
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        if (timeout) begin
          state_d = ST_FETCH;
        end else begin
          mem_req_o = 1'b1;
          iord_o    = 1'b1;
          mem_wr_o  = (op_q == OPCODE_STORE);
          if (mem_ack_i) begin
            if (op_q == OPCODE_LOAD) begin
              state_d = ST_WB;
            end else begin
              instr_done_o = (op_q == OPCODE_STORE);
              state_d      = ST_FETCH;
            end
          end
        end
      end

      ST_WB: begin
        reg_wr_o     = 1'b1;
        mem_to_reg_o = (op_q == OPCODE_LOAD);
        instr_done_o = 1'b1;
        state_d      = ST_FETCH;
      end

      default: state_d = ST_RESET;
    endcase
  end

  always_comb begin
    op_d  = (state_q == ST_DECODE) ? opcode_i : op_q;
    ret_d = instr_done_o ? ret_q + RET_CNT_W'(1) : ret_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RESET;
      op_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ret_q   <= ret_d;
    end
  end

  assign alu_src_b_o   = alu_src_b;
  assign alu_op_o      = alu_op;
  assign ret_cnt_o     = ret_q;
  assign mem_timeout_o = timeout;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit; timeout sequence runs when CTRL_MEM_TIMEOUT_EN is defined.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  opcode;
  logic        ack;
  logic        mem_req, mem_wr, iord, ir_wr, pc_wr, branch, pc_src, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic        mem_to_reg, reg_wr, illegal, instr_done, mem_timeout;
  logic [31:0] ret_cnt;
  logic [2:0]  state;
  logic [16:0] outv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .TIMEOUT_CYCLES(4),
    .RET_CNT_W     (32)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .opcode_i     (opcode),
    .mem_ack_i    (ack),
    .mem_req_o    (mem_req),
    .mem_wr_o     (mem_wr),
    .iord_o       (iord),
    .ir_wr_o      (ir_wr),
    .pc_wr_o      (pc_wr),
    .branch_o     (branch),
    .pc_src_o     (pc_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .mem_to_reg_o (mem_to_reg),
    .reg_wr_o     (reg_wr),
    .illegal_o    (illegal),
    .instr_done_o (instr_done),
    .ret_cnt_o    (ret_cnt),
    .mem_timeout_o(mem_timeout),
    .state_o      (state)
  );

  // {timeout, req, wr, iord, ir_wr, pc_wr, branch, pc_src, srcA, srcB[1:0], op[1:0], m2r, reg_wr, illegal, done}
  assign outv = {mem_timeout, mem_req, mem_wr, iord, ir_wr, pc_wr, branch, pc_src, alu_src_a,
                 alu_src_b, alu_op, mem_to_reg, reg_wr, illegal, instr_done};

  localparam logic [4:0] OP_LD = 5'b00000, OP_I = 5'b00100, OP_ST = 5'b01000,
                         OP_R  = 5'b01100, OP_BR = 5'b11000, OP_BAD = 5'b11111;

  localparam logic [16:0] O_NONE   = 17'h00000;
  localparam logic [16:0] O_FWAIT  = 17'h08000;
  localparam logic [16:0] O_FACK   = 17'h09840;
  localparam logic [16:0] O_DEC    = 17'h00080;
  localparam logic [16:0] O_DECILL = 17'h00082;
  localparam logic [16:0] O_EX_R   = 17'h00120;
  localparam logic [16:0] O_EX_I   = 17'h001B0;
  localparam logic [16:0] O_EX_LS  = 17'h00180;
  localparam logic [16:0] O_EX_BR  = 17'h00711;
  localparam logic [16:0] O_MEM_LD = 17'h0A000;
  localparam logic [16:0] O_MEM_ST = 17'h0E000;
  localparam logic [16:0] O_ST_ACK = 17'h0E001;
  localparam logic [16:0] O_WB_R   = 17'h00005;
  localparam logic [16:0] O_WB_LD  = 17'h0000D;
  localparam logic [16:0] O_TMO    = 17'h10000;

  typedef struct {
    logic        rst_n;
    logic [4:0]  op;
    logic        ack;
    logic [2:0]  st;
    logic [16:0] out;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] op, input logic a);
    @(negedge clk);
    rst_n  = r;
    opcode = op;
    ack    = a;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [16:0] o,
                         input logic [31:0] rc);
    chk({tag, " state"}, {29'd0, state}, {29'd0, st});
    chk({tag, " outs"}, {15'd0, outv}, {15'd0, o});
    chk({tag, " ret"}, ret_cnt, rc);
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = '0;
    ack    = 1'b0;

    // R-type, zero wait; opcode_i changed in EXEC to show the latched opcode is used
    tbl.push_back('{1'b1, OP_R,  1'b0, 3'd0, O_NONE,   32'd0});
    tbl.push_back('{1'b1, OP_R,  1'b1, 3'd1, O_FACK,   32'd0});
    tbl.push_back('{1'b1, OP_R,  1'b0, 3'd2, O_DEC,    32'd0});
    tbl.push_back('{1'b1, OP_LD, 1'b0, 3'd3, O_EX_R,   32'd0});
    tbl.push_back('{1'b1, OP_LD, 1'b0, 3'd5, O_WB_R,   32'd0});
    // I-arith
    tbl.push_back('{1'b1, OP_I,  1'b1, 3'd1, O_FACK,   32'd1});
    tbl.push_back('{1'b1, OP_I,  1'b0, 3'd2, O_DEC,    32'd1});
    tbl.push_back('{1'b1, OP_I,  1'b0, 3'd3, O_EX_I,   32'd1});
    tbl.push_back('{1'b1, OP_I,  1'b0, 3'd5, O_WB_R,   32'd1});
    // Load, ack delayed 3 cycles in MEM
    tbl.push_back('{1'b1, OP_LD, 1'b1, 3'd1, O_FACK,   32'd2});
    tbl.push_back('{1'b1, OP_LD, 1'b0, 3'd2, O_DEC,    32'd2});
    tbl.push_back('{1'b1, OP_LD, 1'b0, 3'd3, O_EX_LS,  32'd2});
    tbl.push_back('{1'b1, OP_LD, 1'b0, 3'd4, O_MEM_LD, 32'd2});
    tbl.push_back('{1'b1, OP_LD, 1'b0, 3'd4, O_MEM_LD, 32'd2});
    tbl.push_back('{1'b1, OP_LD, 1'b0, 3'd4, O_MEM_LD, 32'd2});
    tbl.push_back('{1'b1, OP_LD, 1'b1, 3'd4, O_MEM_LD, 32'd2});
    tbl.push_back('{1'b1, OP_LD, 1'b0, 3'd5, O_WB_LD,  32'd2});
    // Branch
    tbl.push_back('{1'b1, OP_BR, 1'b1, 3'd1, O_FACK,   32'd3});
    tbl.push_back('{1'b1, OP_BR, 1'b0, 3'd2, O_DEC,    32'd3});
    tbl.push_back('{1'b1, OP_BR, 1'b0, 3'd3, O_EX_BR,  32'd3});
    // Illegal opcode, then a fetch wait cycle
    tbl.push_back('{1'b1, OP_BAD, 1'b1, 3'd1, O_FACK,  32'd4});
    tbl.push_back('{1'b1, OP_BAD, 1'b0, 3'd2, O_DECILL, 32'd4});
    tbl.push_back('{1'b1, OP_BAD, 1'b0, 3'd1, O_FWAIT, 32'd4});
    // Store, stray acks in DECODE/EXEC must be ignored
    tbl.push_back('{1'b1, OP_ST, 1'b1, 3'd1, O_FACK,   32'd4});
    tbl.push_back('{1'b1, OP_ST, 1'b1, 3'd2, O_DEC,    32'd4});
    tbl.push_back('{1'b1, OP_R,  1'b1, 3'd3, O_EX_LS,  32'd4});
    tbl.push_back('{1'b1, OP_R,  1'b1, 3'd4, O_ST_ACK, 32'd4});
    tbl.push_back('{1'b1, OP_R,  1'b0, 3'd1, O_FWAIT,  32'd5});

    @(negedge clk);
    @(negedge clk);
    #1;
    chk_all("reset", 3'd0, O_NONE, 32'd0);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].op, tbl[i].ack);
      chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].out, tbl[i].ret);
    end

    // Async reset in the middle of a stalled Store
    step(1'b1, OP_ST, 1'b1);
    chk_all("rst_fetch", 3'd1, O_FACK, 32'd5);
    step(1'b1, OP_ST, 1'b0);
    step(1'b1, OP_ST, 1'b0);
    step(1'b1, OP_ST, 1'b0);
    chk_all("rst_mem", 3'd4, O_MEM_ST, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async req", {31'd0, mem_req}, 32'd0);
    chk("rst_async wr", {31'd0, mem_wr}, 32'd0);
    chk_all("rst_async", 3'd0, O_NONE, 32'd0);
    step(1'b1, OP_ST, 1'b0);
    chk_all("rst_release", 3'd0, O_NONE, 32'd0);
    step(1'b1, OP_ST, 1'b0);
    chk_all("rst_then_fetch", 3'd1, O_FWAIT, 32'd0);

`ifdef CTRL_MEM_TIMEOUT_EN
    // Store with no ack: abort on the 4th request cycle, no retire
    step(1'b1, OP_ST, 1'b1);
    step(1'b1, OP_ST, 1'b0);
    step(1'b1, OP_ST, 1'b0);
    chk_all("tmo_exec", 3'd3, O_EX_LS, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, OP_ST, 1'b0);
      chk_all($sformatf("tmo_wait%0d", k), 3'd4, O_MEM_ST, 32'd0);
    end
    step(1'b1, OP_ST, 1'b0);
    chk_all("tmo_abort", 3'd4, O_TMO, 32'd0);
    step(1'b1, OP_ST, 1'b0);
    chk_all("tmo_refetch", 3'd1, O_FWAIT, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
